// File: rtl/arbiter_types_pkg.sv
// Arbiter FSM state encoding and the fairness streak counter width.
package arbiter_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int unsigned STREAK_W = 3;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM status encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one RAM port between instruction fetch and data
// accesses. Data has strict priority unless ARB_FAIRNESS_EN is defined, in
// which case a pending fetch is forced after STARVE_MAX consecutive data
// completions.
module mem_arbiter
  import cpu_types_pkg::*;
  import arbiter_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  // The streak counter is 3 bits wide; a larger threshold could never trip.
  if (STARVE_MAX > 7) begin : g_starve_range
    $error("STARVE_MAX must fit the 3-bit streak counter");
  end

  arb_state_t state_q, state_d;
  logic       dreq;
  logic       fetch_first;

  assign dreq = dREN | dWEN;

`ifdef ARB_FAIRNESS_EN
  logic [STREAK_W-1:0] streak_q, streak_d;

  // Streak register, cleared asynchronously with the FSM.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) streak_q <= '0;
    else       streak_q <= streak_d;
  end

  // Count data completions that left a fetch waiting; any fetch completion clears.
  always_comb begin
    streak_d = streak_q;
    if (state_q == IGNT && iREN && ramstate == ACCESS) begin
      streak_d = '0;
    end else if (state_q == DGNT && dreq && ramstate == ACCESS && iREN &&
                 streak_q != '1) begin
      streak_d = streak_q + 1'b1;
    end
  end

  assign fetch_first = iREN && (32'(streak_q) >= STARVE_MAX);
`else
  assign fetch_first = 1'b0;
`endif

  // FSM state register; reset forces IDLE, which drops RAM enables at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and RAM/requester outputs.
  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = ramload;
    dload    = ramload;
    unique case (state_q)
      IDLE: begin
        if (fetch_first)  state_d = IGNT;
        else if (dreq)    state_d = DGNT;
        else if (iREN)    state_d = IGNT;
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (dWEN) ramWEN = 1'b1;
        else      ramREN = dREN;
        if (!dreq) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait   = 1'b0;
          state_d = IDLE;
        end else if (ramstate == ERROR) begin
          state_d = IDLE;
        end
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait   = 1'b0;
          state_d = IDLE;
        end else if (ramstate == ERROR) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, consecutive data grants allowed before a pending fetch is forced (used only with ARB_FAIRNESS_EN).
REQ-002 The block SHALL use reset nRST, asynchronous, active-low, and clock CLK.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- iREN  in  1  instruction fetch request
- iaddr  in  32  fetch address
- iwait  out  1  fetch not complete (0 = hit this cycle)
- iload  out  32  fetch data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  data access not complete
- dload  out  32  read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR

Function
REQ-004 The FSM SHALL have states IDLE, IGNT and DGNT.
REQ-005 In IDLE, any dREN|dWEN SHALL select DGNT next cycle; otherwise iREN SHALL select IGNT; otherwise the FSM stays in IDLE.
REQ-006 In IDLE, ramREN and ramWEN SHALL be 0, ramaddr SHALL be 0, and iwait=dwait=1.
REQ-007 In DGNT, ram* SHALL be driven combinationally from the data side.
- ramaddr=daddr, ramstore=dstore.
- If dWEN=1, ramWEN=1 and ramREN=0 (write wins when both are asserted).
- Otherwise ramREN=dREN.
REQ-008 In IGNT, ramREN=iREN, ramWEN=0 and ramaddr=iaddr.
REQ-009 The granted side's wait SHALL be 0 only in a cycle where ramstate==ACCESS; the FSM then returns to IDLE.
REQ-010 dload and iload SHALL equal ramload combinationally. The non-granted side's wait SHALL stay 1.
REQ-011 ramstate BUSY or FREE in a grant state SHALL hold that state with wait=1.
REQ-012 ramstate ERROR in a grant state SHALL return the FSM to IDLE with wait=1, so the request is re-arbitrated.
REQ-013 If the granted request drops mid-grant (requester abort), the FSM SHALL return to IDLE next cycle and ram enables SHALL drop in that same cycle.
REQ-014 Minimum latency from request to wait=0 SHALL be 1 cycle (request seen in IDLE, ACCESS in the first grant cycle). At most one access SHALL complete per 2 cycles.
REQ-015 The block SHALL never assert ramREN and ramWEN together.

Reset
REQ-016 While nRST=0, the FSM SHALL be IDLE, ramREN=ramWEN=0, iwait=dwait=1, and the streak counter SHALL be 0.
REQ-017 Reset assertion mid-grant SHALL drop ram enables asynchronously. No partial access SHALL be signalled complete.

Configuration
REQ-018 With ARB_FAIRNESS_EN defined, a 3-bit streak counter SHALL track data completions.
- It increments on each data completion while iREN=1.
- It clears on any fetch completion.
- In IDLE, if streak>=STARVE_MAX and iREN=1, IGNT SHALL be chosen over a data request.
REQ-019 Without ARB_FAIRNESS_EN, data SHALL have strict priority, no counter SHALL exist, and STARVE_MAX SHALL be ignored.

Structure
REQ-020 The ramstate enum and word_t SHALL come from cpu_types_pkg. The arbiter FSM state enum SHALL be declared in a shared package, arbiter_types_pkg.
REQ-021 The block SHALL be a single module; no sub-module is required.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Fetch only: iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C220004 -> iwait=0 exactly once, iload=0x8C220004, FSM back to IDLE.
- Simultaneous: iREN=1 and dREN=1 with daddr=0x100 -> DGNT first, ramaddr=0x100, dwait=0 on ACCESS; then IGNT, ramaddr=iaddr.
- Write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; with dREN=1 as well, ramREN still 0.
- Error retry: ramstate=ERROR in DGNT -> IDLE, dwait=1; a re-grant followed by ACCESS completes the access.
- Reset mid-grant: nRST=0 while in DGNT with ramWEN=1 -> ramWEN=0 the same cycle, dwait=1, FSM IDLE after release.
- Fairness (ARB_FAIRNESS_EN, STARVE_MAX=4): dREN and iREN held high -> the 5th grant goes to fetch. Without the macro, fetch is never granted while dREN=1.
